// File: rtl/pc_stall_ctrl.sv
// pc_stall_ctrl: pipeline sequencer for the PC and the IF/ID and ID/EX latches.
// It detects load-use and mult/div-busy hazards on the instruction in ID and
// inserts branch-resolution bubbles after an accepted branch.
//
// Handshake/output semantics: every output is Mealy (decoded from the current
// state and this cycle's inputs). hazard freezes PC and IF/ID and comes with
// IDEX_Flush. BranchBubble freezes the PC and comes with IFID_Flush. The two
// freeze sources are never active in the same cycle. While Reset is low, every
// output is forced to 0 so the PC loads its reset vector.
//
// Optional feature: define PC_PERF_CNT_EN to build the saturating
// StallCnt/BubbleCnt performance counters. When it is undefined, both ports
// stay present, are tied to 0, and no counter flops exist.
module pc_stall_ctrl #(
  parameter int BR_SLOTS = 1,   // bubble cycles after an accepted branch (0..15)
  parameter int LD_STALL = 1,   // total stall cycles per load-use hit (1..15)
  parameter int PERF_W   = 16   // width of the performance counters
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UsesRs,
  input  logic              ID_UsesRt,
  input  logic              ID_Branch,
  input  logic              ID_MdUse,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_Rd,
  input  logic              MD_Busy,
  output logic              hazard,
  output logic              BranchBubble,
  output logic              IDEX_Flush,
  output logic              IFID_Flush,
  output logic [1:0]        State,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] BubbleCnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LDWAIT = 2'd1,
    ST_BRWAIT = 2'd2,
    ST_MDWAIT = 2'd3
  } state_t;

  // Counter reload values. A load-use hit spends its first stall cycle in RUN,
  // so LDWAIT only has to cover the remaining LD_STALL-1 cycles.
  localparam logic [3:0] LD_RELOAD = 4'(LD_STALL - 1);
  localparam logic [3:0] BR_RELOAD = 4'(BR_SLOTS);
  localparam bit         LD_MULTI  = (LD_STALL > 1);
  localparam bit         BR_EN     = (BR_SLOTS != 0);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic ld_use;
  logic md_use;
  logic rs_hit;
  logic rt_hit;

  // Raw (pre-reset-gating) Mealy outputs.
  logic hazard_c;
  logic bubble_c;
  logic idex_flush_c;
  logic ifid_flush_c;

  // Hazard detection on the instruction sitting in ID. Register r0 never
  // carries a real dependency, so a load into r0 is not a hazard.
  always_comb begin
    rs_hit = ID_UsesRs && (ID_Rs == EX_Rd);
    rt_hit = ID_UsesRt && (ID_Rt == EX_Rd);
    ld_use = EX_MemRead && (EX_Rd != 5'd0) && (rs_hit || rt_hit);
    md_use = ID_MdUse && MD_Busy;
  end

  // Next-state, stall counter and Mealy outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hazard_c     = 1'b0;
    bubble_c     = 1'b0;
    idex_flush_c = 1'b0;
    ifid_flush_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (md_use) begin
          // mult/div wins over a simultaneous load-use hit
          hazard_c     = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = ST_MDWAIT;
        end else if (ld_use) begin
          hazard_c     = 1'b1;
          idex_flush_c = 1'b1;
          if (LD_MULTI) begin
            state_d = ST_LDWAIT;
            cnt_d   = LD_RELOAD;
          end
        end else if (ID_Branch && BR_EN) begin
          // Branch accepted: it moves on this cycle, bubbles start next cycle.
          state_d = ST_BRWAIT;
          cnt_d   = BR_RELOAD;
        end
      end
      ST_LDWAIT: begin
        hazard_c     = 1'b1;
        idex_flush_c = 1'b1;
        cnt_d        = cnt_q - 4'd1;
        // cnt of 0 can only arise from a corrupted state; leave rather than wrap
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_BRWAIT: begin
        bubble_c     = 1'b1;
        ifid_flush_c = 1'b1;
        cnt_d        = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end
      ST_MDWAIT: begin
        if (MD_Busy) begin
          hazard_c     = 1'b1;
          idex_flush_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and stall-counter registers; reset drops any pending stall.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // While reset is held, every output reads 0 so the PC takes its reset vector.
  always_comb begin
    hazard       = Reset & hazard_c;
    BranchBubble = Reset & bubble_c;
    IDEX_Flush   = Reset & idex_flush_c;
    IFID_Flush   = Reset & ifid_flush_c;
    State        = Reset ? state_q : ST_RUN;
  end

`ifdef PC_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counts of freeze cycles as seen by the PC.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hazard && (stall_cnt_q != {PERF_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (BranchBubble && (bubble_cnt_q != {PERF_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
    end
  end

  // Performance counter registers, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`else
  assign StallCnt  = '0;
  assign BubbleCnt = '0;
`endif

endmodule
